// File: rtl/snn_fc_pkg.sv
// Shared types, constants and the 16-bit narrowing helper for the FC spiking layer.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
// Build option: FC_SAT_EN selects saturating narrow16; otherwise it wraps (two's complement).
package snn_fc_pkg;

    localparam int Q_W         = 16;   // Q3.13 membrane / weight width
    localparam int X_W         = 3;    // unsigned Q1.2 pooled input width
    localparam int X_FRAC      = 2;    // fractional bits of the input, removed after the multiply
    localparam int DECAY_SHIFT = 2;    // leak = v * 0.25
    localparam int NARROW_IN_W = 48;   // widest sum narrow16 accepts

    localparam logic signed [Q_W-1:0] THRESH = 16'sh1000;   // 0.5 in Q3.13

    localparam logic signed [NARROW_IN_W-1:0] Q_MAX = 48'sd32767;
    localparam logic signed [NARROW_IN_W-1:0] Q_MIN = -48'sd32768;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        UPDATE,
        DONE
    } fc_state_t;

    // Reduce a wide signed sum to Q3.13.
    function automatic logic signed [Q_W-1:0] narrow16(input logic signed [NARROW_IN_W-1:0] a);
`ifdef FC_SAT_EN
        if (a > Q_MAX) begin
            return 16'sh7FFF;
        end else if (a < Q_MIN) begin
            return 16'sh8000;
        end else begin
            return a[Q_W-1:0];
        end
`else
        return a[Q_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/fc_lif_layer_lif.sv
// Combinational LIF membrane update: v_new = narrow16(acc + leak), spike = v_new >= 0.5.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: acc (signed ACC_W weighted sum incl. bias), v_old/s_old (stored neuron state),
//        v_new (Q3.13 membrane), spike (threshold crossing). Saturation set by FC_SAT_EN.
module lif_update
    import snn_fc_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [Q_W-1:0]   v_old,
    input  logic                    s_old,
    output logic signed [Q_W-1:0]   v_new,
    output logic                    spike
);

    logic signed [Q_W-1:0] leak_sh;
    logic signed [Q_W-1:0] leak;
    logic signed [ACC_W:0] sum;

    always_comb begin
        // Kept as its own signed assignment so the arithmetic shift is never
        // demoted to a logical one by an unsigned operand in the mux below.
        leak_sh = v_old >>> DECAY_SHIFT;
        // A neuron that spiked last step restarts from zero: no carried leak.
        leak    = s_old ? 16'sh0000 : leak_sh;
        sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(leak);
        v_new   = narrow16(NARROW_IN_W'(sum));
        spike   = (v_new >= THRESH);
    end

endmodule

// File: rtl/fc_lif_layer.sv
// Fully-connected LIF layer: N_OUT neurons, each a serial MAC over N_IN pooled inputs plus bias.
// Latency: N_IN+3 cycles per neuron; done pulses N_OUT*(N_IN+3)+1 cycles after the start edge.
// Backpressure: none; start is ignored while busy, weight BRAM must return data 1 cycle after w_rd_en.
// Ports: start/clear_state (sampled in IDLE), x_in (latched at start), w_rd_en/w_addr/w_data
//        (weight BRAM), busy/done (status), spike_out/v_out (persistent neuron state).
// Build option: FC_SAT_EN makes the membrane narrowing saturate instead of wrap.
module fc_lif_layer
    import snn_fc_pkg::*;
#(
    parameter int N_IN  = 49,
    parameter int N_OUT = 10,
    parameter int AW    = 10,
    parameter int ACC_W = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clear_state,
    input  logic [N_IN*X_W-1:0]    x_in,
    output logic                   w_rd_en,
    output logic [AW-1:0]          w_addr,
    input  logic [Q_W-1:0]         w_data,
    output logic                   busy,
    output logic                   done,
    output logic [N_OUT-1:0]       spike_out,
    output logic [N_OUT*Q_W-1:0]   v_out
);

    localparam int IDX_W = $clog2(N_IN + 1);
    localparam int N_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN);     // bias word index
    localparam logic [N_W-1:0]   LAST_N   = N_W'(N_OUT - 1);

    fc_state_t state;
    fc_state_t state_nxt;

    logic [IDX_W-1:0]            idx;        // word index within the current neuron
    logic [IDX_W-1:0]            rd_idx_q;   // index of the word arriving on w_data
    logic                        rd_vld_q;   // w_data carries a word this cycle
    logic [N_W-1:0]              n_cnt;
    logic [AW-1:0]               addr;
    logic [(N_IN+1)*X_W-1:0]     x_q;        // padded with a zero element at the bias slot
    logic signed [ACC_W-1:0]     acc;
    logic [N_OUT*Q_W-1:0]        v_q;
    logic [N_OUT-1:0]            s_q;

    logic [X_W-1:0]              x_sel;
    logic signed [Q_W+X_W:0]     prod;
    logic signed [Q_W+X_W:0]     prod_sh;
    logic signed [ACC_W-1:0]     mac_term;

    logic signed [Q_W-1:0]       v_old;
    logic                        s_old;
    logic signed [Q_W-1:0]       v_new;
    logic                        spike_new;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = FETCH;
            // The last fetch issues the bias read; one MAC cycle drains it.
            FETCH:   if (idx == LAST_IDX) state_nxt = MAC;
            MAC:     state_nxt = UPDATE;
            UPDATE:  state_nxt = (n_cnt == LAST_N) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_en = (state == FETCH);
        busy    = (state != IDLE);
        done    = (state == DONE);
    end

    assign w_addr    = addr;
    assign spike_out = s_q;
    assign v_out     = v_q;

    // ------------------------------------------------------------------
    // MAC operand: weight * {0,x} in Q3.13 x Q1.2, rescaled back to Q3.13.
    // ------------------------------------------------------------------
    always_comb begin
        x_sel   = x_q[rd_idx_q*X_W +: X_W];
        prod    = (Q_W+X_W+1)'($signed(w_data)) * (Q_W+X_W+1)'($signed({1'b0, x_sel}));
        prod_sh = prod >>> X_FRAC;
        if (rd_idx_q == LAST_IDX) begin
            mac_term = ACC_W'($signed(w_data));
        end else begin
            mac_term = ACC_W'(prod_sh);
        end
    end

    // ------------------------------------------------------------------
    // LIF update for the neuron currently being finished
    // ------------------------------------------------------------------
    assign v_old = $signed(v_q[n_cnt*Q_W +: Q_W]);
    assign s_old = s_q[n_cnt];

    lif_update #(
        .ACC_W (ACC_W)
    ) u_lif (
        .acc   (acc),
        .v_old (v_old),
        .s_old (s_old),
        .v_new (v_new),
        .spike (spike_new)
    );

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            rd_idx_q <= '0;
            rd_vld_q <= 1'b0;
            n_cnt    <= '0;
            addr     <= '0;
            x_q      <= '0;
            acc      <= '0;
            v_q      <= '0;
            s_q      <= '0;
        end else begin
            // Read-data tracking: the BRAM answers one cycle after each fetch.
            rd_vld_q <= (state == FETCH);
            rd_idx_q <= idx;

            if (rd_vld_q) begin
                acc <= acc + mac_term;
            end

            unique case (state)
                IDLE: begin
                    if (clear_state) begin
                        v_q <= '0;
                        s_q <= '0;
                    end
                    if (start) begin
                        x_q   <= {X_W'(0), x_in};
                        n_cnt <= '0;
                        idx   <= '0;
                        addr  <= '0;
                        acc   <= '0;
                    end
                end
                FETCH: begin
                    // Neurons are laid out back to back, so the address simply
                    // keeps counting across neuron boundaries.
                    addr <= addr + 1'b1;
                    idx  <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                UPDATE: begin
                    v_q[n_cnt*Q_W +: Q_W] <= v_new;
                    s_q[n_cnt]            <= spike_new;
                    acc                   <= '0;
                    if (n_cnt != LAST_N) begin
                        n_cnt <= n_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_lif_layer.sv
// Self-checking bench for fc_lif_layer: BRAM model, reference LIF model and result scoreboard.
// Cycle numbering: cycle 1 is the clock period right after the start edge.
module tb_fc_lif_layer;

    localparam int N_IN  = 49;
    localparam int N_OUT = 10;
    localparam int AW    = 10;
    localparam int ACC_W = 24;
    localparam int STRIDE = N_IN + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  clear_state;
    logic [N_IN*3-1:0]     x_in;
    logic                  w_rd_en;
    logic [AW-1:0]         w_addr;
    logic [15:0]           w_data = 16'h0000;
    logic                  busy;
    logic                  done;
    logic [N_OUT-1:0]      spike_out;
    logic [N_OUT*16-1:0]   v_out;

    fc_lif_layer #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .AW    (AW),
        .ACC_W (ACC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .clear_state (clear_state),
        .x_in        (x_in),
        .w_rd_en     (w_rd_en),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .busy        (busy),
        .done        (done),
        .spike_out   (spike_out),
        .v_out       (v_out)
    );

    always #5 clk = ~clk;

    // Weight BRAM: synchronous read, one-cycle latency.
    logic [15:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (w_rd_en) w_data <= mem[w_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int model_v [N_OUT];
    bit model_s [N_OUT];

    typedef struct {
        logic [N_OUT*16-1:0] v;
        logic [N_OUT-1:0]    s;
    } exp_t;
    exp_t sb [$];

    function automatic int narrow(input longint s);
        logic [15:0] t;
`ifdef FC_SAT_EN
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return int'(s);
`else
        t = s[15:0];
        return int'($signed(t));
`endif
    endfunction

    task automatic model_clear();
        for (int n = 0; n < N_OUT; n++) begin
            model_v[n] = 0;
            model_s[n] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [N_IN*3-1:0] x);
        exp_t e;
        for (int n = 0; n < N_OUT; n++) begin
            longint acc = 0;
            int     leak;
            int     nv;
            for (int i = 0; i < N_IN; i++) begin
                int w  = int'($signed(mem[n*STRIDE+i]));
                int xi = int'(x[i*3 +: 3]);
                acc += longint'((w * xi) >>> 2);
            end
            acc += longint'(int'($signed(mem[n*STRIDE+N_IN])));
            leak = model_s[n] ? 0 : (model_v[n] >>> 2);
            nv = narrow(acc + longint'(leak));
            model_v[n] = nv;
            model_s[n] = (nv >= 4096);
        end
        for (int n = 0; n < N_OUT; n++) begin
            e.v[n*16 +: 16] = 16'(model_v[n]);
            e.s[n]          = model_s[n];
        end
        sb.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [N_IN*3-1:0] x_all(input logic [2:0] v);
        logic [N_IN*3-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*3 +: 3] = v;
        return r;
    endfunction

    function automatic logic [N_IN*3-1:0] x_rand();
        logic [N_IN*3-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*3 +: 3] = 3'($urandom_range(0, 7));
        return r;
    endfunction

    task automatic load_mem(input logic [15:0] w, input logic [15:0] b);
        for (int n = 0; n < N_OUT; n++) begin
            for (int i = 0; i < N_IN; i++) mem[n*STRIDE+i] = w;
            mem[n*STRIDE+N_IN] = b;
        end
    endtask

    task automatic load_rand();
        for (int a = 0; a < N_OUT*STRIDE; a++) mem[a] = 16'($urandom_range(0, 16'hFFFF));
    endtask

    // One timestep: predict, drive start, watch the run, compare on done.
    task automatic run_step(input logic [N_IN*3-1:0] x, input bit cl, input bit hs);
        exp_t e;
        int   cyc;
        int   exp_addr;
        if (cl) model_clear();
        model_step(x);
        @(negedge clk);
        start       = 1'b1;
        clear_state = cl;
        x_in        = x;
        @(posedge clk);
        #1;
        start       = 1'b0;
        clear_state = 1'b0;
        x_in        = x_rand();   // must not influence the running step
        cyc      = 1;
        exp_addr = 0;
        while (!done && cyc < 1000) begin
            if (hs) begin
                if (cyc == 1) check_eq("busy_c1", busy, 1);
                if (w_rd_en) begin
                    check_eq("w_addr", w_addr, exp_addr);
                    exp_addr++;
                end
                if (cyc == 200) start = 1'b1;
                if (cyc == 201) start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("done_seen", done, 1);
        if (hs) begin
            check_eq("done_latency", cyc, N_OUT*(N_IN+3)+1);
            check_eq("addr_count", exp_addr, N_OUT*STRIDE);
        end
        e = sb.pop_front();
        for (int n = 0; n < N_OUT; n++) begin
            check_eq($sformatf("sb_v%0d", n), v_out[n*16 +: 16], e.v[n*16 +: 16]);
            check_eq($sformatf("sb_s%0d", n), spike_out[n], e.s[n]);
        end
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", done, 0);
        check_eq("busy_after", busy, 0);
    endtask

    initial begin
        int dones;
        rst         = 1'b1;
        start       = 1'b0;
        clear_state = 1'b0;
        x_in        = '0;
        load_mem(16'h0000, 16'h0000);
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_en", w_rd_en, 0);
        check_eq("rst_addr", w_addr, 0);
        check_eq("rst_spike", spike_out, 0);
        check_eq("rst_v_zero", |v_out, 0);
        rst = 1'b0;

        // Threshold crossing, with handshake/latency checks on the first step.
        load_mem(16'h0100, 16'h0000);
        run_step(x_all(3'b100), 1'b1, 1'b1);
        check_eq("thr1_v0", v_out[15:0], 16'h3100);
        check_eq("thr1_v9", v_out[159:144], 16'h3100);
        check_eq("thr1_s", spike_out, 10'h3FF);
        run_step(x_all(3'b100), 1'b0, 1'b0);
        check_eq("thr2_v0", v_out[15:0], 16'h3100);
        check_eq("thr2_s", spike_out, 10'h3FF);

        // Bias-only accumulation and leak.
        load_mem(16'h0100, 16'h0800);
        run_step(x_all(3'b000), 1'b1, 1'b0);
        check_eq("bias1_v0", v_out[15:0], 16'h0800);
        check_eq("bias1_s", spike_out, 0);
        run_step(x_all(3'b000), 1'b0, 1'b0);
        check_eq("bias2_v0", v_out[15:0], 16'h0A00);
        run_step(x_all(3'b000), 1'b0, 1'b0);
        check_eq("bias3_v0", v_out[15:0], 16'h0A80);
        check_eq("bias3_s", spike_out, 0);

        // Negative leak.
        load_mem(16'h0000, 16'hF000);
        run_step(x_all(3'b000), 1'b1, 1'b0);
        check_eq("neg1_v0", v_out[15:0], 16'hF000);
        load_mem(16'h0000, 16'h0000);
        run_step(x_all(3'b000), 1'b0, 1'b0);
        check_eq("neg2_v0", v_out[15:0], 16'hFC00);
        check_eq("neg2_s0", spike_out[0], 0);

        // Overflow of the 16-bit membrane.
        load_mem(16'h7FFF, 16'h0000);
        run_step(x_all(3'b111), 1'b1, 1'b0);
`ifdef FC_SAT_EN
        check_eq("ovf_v0", v_out[15:0], 16'h7FFF);
        check_eq("ovf_s0", spike_out[0], 1);
`else
        check_eq("ovf_v0", v_out[15:0], 16'hDF9E);
        check_eq("ovf_s0", spike_out[0], 0);
`endif

        // Random weights and inputs; the first step clears in the start cycle.
        load_rand();
        run_step(x_rand(), 1'b1, 1'b0);
        run_step(x_rand(), 1'b0, 1'b0);
        load_rand();
        run_step(x_rand(), 1'b0, 1'b0);

        // Reset in the middle of a timestep.
        check_eq("pre_rst_v_nonzero", |v_out, 1);
        @(negedge clk);
        start = 1'b1;
        x_in  = x_all(3'b101);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check_eq("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_rd_en", w_rd_en, 0);
        check_eq("mrst_v_zero", |v_out, 0);
        check_eq("mrst_spike", spike_out, 0);
        model_clear();
        dones = 0;
        for (int c = 0; c < 600; c++) begin
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        check_eq("mrst_no_done", dones, 0);
        run_step(x_rand(), 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
